// File: rtl/pipe_pkg.sv
// Shared types for the pipeline-stage register: occupancy encoding and the
// stage-boundary bundles whose widths size each pipe_stage_reg instance.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } pipe_occ_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_pix_write;
        logic       pc_src;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
        logic [2:0] imm_sel;
        logic       halt;
    } deco_exe_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } deco_exe_data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_pix_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } exe_mem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_val;
        logic [31:0] pc_plus4;
    } exe_mem_data_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [4:0] rd;
    } mem_wb_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
    } mem_wb_data_t;

    localparam int DE_CTRL_W = $bits(deco_exe_ctrl_t);
    localparam int DE_DATA_W = $bits(deco_exe_data_t);
    localparam int EM_CTRL_W = $bits(exe_mem_ctrl_t);
    localparam int EM_DATA_W = $bits(exe_mem_data_t);
    localparam int MW_CTRL_W = $bits(mem_wb_ctrl_t);
    localparam int MW_DATA_W = $bits(mem_wb_data_t);

endpackage

// File: rtl/pipe_occ_ctrl.sv
// Occupancy FSM for pipe_stage_reg: tracks EMPTY/ONE/FULL and issues the
// load strobes that steer the main and skid datapath registers.
module pipe_occ_ctrl
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      accept,
    input  logic      drain,
    input  logic      flush,
    output pipe_occ_e state,
    output logic      load_main,
    output logic      load_skid,
    output logic      main_from_skid
);

    pipe_occ_e state_r;
    pipe_occ_e next_s;
    logic      load_main_s;
    logic      load_skid_s;
    logic      main_from_skid_s;

    // Next-state and load-strobe decode; flush suppresses every load so held data stays put.
    always_comb begin
        next_s           = state_r;
        load_main_s      = 1'b0;
        load_skid_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush) begin
            next_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (accept) begin
                        next_s      = OCC_ONE;
                        load_main_s = 1'b1;
                    end else begin
                        next_s = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        next_s      = OCC_ONE;
                        load_main_s = 1'b1;
                    end else if (accept) begin
                        next_s      = OCC_FULL;
                        load_skid_s = 1'b1;
                    end else if (drain) begin
                        next_s = OCC_EMPTY;
                    end else begin
                        next_s = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a drain can move the state
                    if (drain) begin
                        next_s           = OCC_ONE;
                        main_from_skid_s = 1'b1;
                    end else begin
                        next_s = OCC_FULL;
                    end
                end
                default: begin
                    next_s = OCC_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= next_s;
        end
    end

    assign state          = state_r;
    assign load_main      = load_main_s;
    assign load_skid      = load_skid_s;
    assign main_from_skid = main_from_skid_s;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline-stage register with valid/ready, stall, flush and a 2-entry skid.
// Define PIPE_STAGE_REG_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DE_CTRL_W,
    parameter int DATA_W = DE_DATA_W
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_bubble_cnt
`endif
);

    pipe_occ_e         state_s;
    logic              load_main_s;
    logic              load_skid_s;
    logic              main_from_skid_s;
    logic              accept_s;
    logic              drain_s;
    logic              out_valid_s;
    logic              in_ready_s;
    logic [CTRL_W-1:0] main_ctrl_r;
    logic [DATA_W-1:0] main_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;

    // in_ready depends only on registered state, flush and reset, never on out_ready/stall
    assign out_valid_s = (state_s != OCC_EMPTY);
    assign in_ready_s  = (state_s != OCC_FULL) & ~flush & rst_n;
    assign accept_s    = in_valid & in_ready_s;
    assign drain_s     = out_valid_s & out_ready & ~stall;

    pipe_occ_ctrl u_occ (
        .clk            (clk),
        .rst_n          (rst_n),
        .accept         (accept_s),
        .drain          (drain_s),
        .flush          (flush),
        .state          (state_s),
        .load_main      (load_main_s),
        .load_skid      (load_skid_s),
        .main_from_skid (main_from_skid_s)
    );

    // Main register: refilled from skid first so FIFO order holds, else from upstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_ctrl_r <= {CTRL_W{1'b0}};
            main_data_r <= {DATA_W{1'b0}};
        end else if (main_from_skid_s) begin
            main_ctrl_r <= skid_ctrl_r;
            main_data_r <= skid_data_r;
        end else if (load_main_s) begin
            main_ctrl_r <= in_ctrl;
            main_data_r <= in_data;
        end
    end

    // Skid register: captures the entry that arrives while main is blocked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ctrl_r <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
        end else if (load_skid_s) begin
            skid_ctrl_r <= in_ctrl;
            skid_data_r <= in_data;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_ctrl  = out_valid_s ? main_ctrl_r : {CTRL_W{1'b0}};
    assign out_data  = main_data_r;

`ifdef PIPE_STAGE_REG_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;

    // Saturating perf counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            stall_cnt_r  <= {CNT_W{1'b0}};
            bubble_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (out_valid_s && !drain_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (!out_valid_s && !flush && (bubble_cnt_r != CNT_MAX)) begin
                bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt_r;
    assign perf_bubble_cnt = bubble_cnt_r;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register that replaces the fixed per-stage structs (deco->exe, exe->mem, mem->wb) with one reusable block.
- Carries a control bundle and a data bundle separately, with a valid/ready handshake, stall, flush and a 2-entry skid buffer.
- Control bits are zeroed whenever the stage holds a bubble, so write enables (regWrite, memWrite, memPixWrite, pcSrc) never fire spuriously.
- Instantiated once per stage boundary; the core top-level is unchanged apart from the packed struct casts.

Parameters:
- CTRL_W, 16, width of the control bundle; zeroed on bubble or flush.
- DATA_W, 160, width of the data bundle; holds its last value on bubble.
- CNT_W, 32, width of the perf counters (used only with the optional feature).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all held and incoming entries.
- stall  in  1  hazard-unit hold; while high the downstream handshake is treated as out_ready=0.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control bundle; all-zero when out_valid=0.
- out_data  out  DATA_W  data bundle.

Behaviour:
- Definitions: accept = in_valid & in_ready. drain = out_valid & out_ready & ~stall.
- Storage: main register (drives the outputs) and skid register. Occupancy FSM has states EMPTY, ONE, FULL.
- in_ready = (state != FULL) & ~flush & rst_n. There is no combinational path from out_ready or stall to in_ready.
- out_valid = (state != EMPTY). out_ctrl = out_valid ? main_ctrl : 0. out_data = main_data.
- Latency: an entry accepted at edge N is visible on the outputs after edge N. With ready held high, throughput is 1 entry/cycle.
- EMPTY:
  - accept -> ONE, main <= in.
- ONE:
  - accept & drain -> ONE, main <= in.
  - accept & ~drain -> FULL, skid <= in.
  - ~accept & drain -> EMPTY.
  - otherwise hold.
- FULL:
  - drain -> ONE, main <= skid.
  - otherwise hold. No accept is possible in FULL.
- Order: FIFO order is always preserved. The skid entry never overtakes main.
- flush (priority over everything except reset): next state EMPTY. An input presented in the same cycle is discarded. out_data keeps its value and out_ctrl reads 0 from the next cycle.
- stall & flush together: flush wins.
- stall held in FULL: outputs stay constant and in_ready stays 0 for the whole stall.
- Reset, asynchronous, including mid-operation: state EMPTY, main/skid cleared to 0, out_valid=0, out_ctrl=0, out_data=0, in_ready=0 while rst_n is low and 1 in the first cycle after release. Held entries are lost.
- Protocol: out_valid is never withdrawn without a drain, flush or reset. out_ctrl/out_data are stable while out_valid & ~drain.

Optional Feature:
- Macro: PIPE_STAGE_REG_PERF_EN.
- Defined: adds ports perf_clr (in, 1), perf_stall_cnt (out, CNT_W) and perf_bubble_cnt (out, CNT_W).
  - perf_stall_cnt increments each cycle with out_valid & ~drain.
  - perf_bubble_cnt increments each cycle with out_valid=0 & ~flush.
  - Both counters saturate at all-ones.
  - perf_clr zeroes both synchronously and has priority over increment.
  - Reset value 0.
- Undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] pipe_occ_e {OCC_EMPTY, OCC_ONE, OCC_FULL}.
  - Localparams for the default CTRL_W/DATA_W of each stage boundary, derived with $bits of the existing stage structs.
- Sub-module pipe_occ_ctrl: the occupancy FSM.
  - Inputs: accept, drain, flush.
  - Outputs: state, load_main, load_skid, main_from_skid.
- Datapath registers stay in pipe_stage_reg.

Test Plan (CTRL_W=8, DATA_W=32):
- Streaming: out_ready=1, in_valid=1, data 0x1..0x8, ctrl 0xA5 -> out_valid from cycle 1, out_data 0x1..0x8 in consecutive cycles, in_ready never 0.
- Backpressure: send 0x11, 0x22, 0x33 with out_ready=0 -> state FULL after 0x22, in_ready=0, 0x33 held upstream. Release out_ready -> outputs 0x11, 0x22, 0x33 in order with no loss or duplication.
- Stall: in FULL, stall=1 for 5 cycles with out_ready=1 -> outputs frozen at 0x11, in_ready=0. After stall drops, drain resumes.
- Flush: state FULL, flush=1 with in_valid=1, data 0x44 -> next cycle out_valid=0, out_ctrl=0x00, in_ready=1, and 0x44 never appears.
- Reset mid-operation: rst_n low for 1 cycle while FULL -> out_valid=0, out_ctrl=0, out_data=0 immediately (asynchronous), in_ready=1 after release.
- PERF_EN: 3 stall cycles then 2 empty cycles -> perf_stall_cnt=3, perf_bubble_cnt=2. Pulse perf_clr -> both 0. Preload near all-ones and check saturation.
